// File: rtl/axi4lite_mem_pkg.sv
// Shared encodings and constants for the AXI4-Lite memory responder.
package axi4lite_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_READ = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] ERR_RDATA  = 32'h0;

endpackage

// File: rtl/axi4lite_mem_slave_if.sv
// AXI4-Lite bus bundle; names mirror the core's master port.
// A beat transfers on the rising clk edge where valid and ready are both high;
// valid never waits on ready, and every ready/valid driven by the slave is a flop.
interface axi4lite_mem_slave_if;
  logic [31:0] AWdata;
  logic        AWvalid;
  logic        AWready;
  logic [2:0]  AWprot;
  logic [31:0] Wdata;
  logic [3:0]  Wstrb;
  logic        Wvalid;
  logic        Wready;
  logic        Bvalid;
  logic        Bready;
  logic [31:0] ARdata;
  logic        ARvalid;
  logic        ARready;
  logic [2:0]  ARprot;
  logic [31:0] Rdata;
  logic        Rvalid;
  logic        RReady;

  modport slave (
    input  AWdata, AWvalid, AWprot, Wdata, Wstrb, Wvalid, Bready,
    input  ARdata, ARvalid, ARprot, RReady,
    output AWready, Wready, Bvalid, ARready, Rdata, Rvalid
  );

  modport master (
    output AWdata, AWvalid, AWprot, Wdata, Wstrb, Wvalid, Bready,
    output ARdata, ARvalid, ARprot, RReady,
    input  AWready, Wready, Bvalid, ARready, Rdata, Rvalid
  );
endinterface

// File: rtl/axi4lite_mem_array.sv
// Word-organised 1W1R RAM: byte-enabled write, registered read, read-before-write.
module axi4lite_mem_array
  import axi4lite_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_BITS];
  logic [31:0] rdata_q;

  // Both updates are non-blocking, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite responder in front of an on-chip RAM; independent read and write FSMs.
module axi4lite_mem_slave
  import axi4lite_mem_pkg::*;
#(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  axi4lite_mem_slave_if.slave       bus,
  output logic                      bus_err,
  output w_state_e                  w_state_dbg,
  output r_state_e                  r_state_dbg
);

  localparam int LSB     = $clog2(WORD_BYTES);
  localparam int TAG_LSB = ADDR_BITS + LSB;

  function automatic logic in_win(input logic [31:0] a);
    return a[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB];
  endfunction

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, bus_err_q, bus_err_d;
  logic [ADDR_BITS-1:0] aw_idx_q, aw_idx_d, ar_idx_q, ar_idx_d;
  logic aw_ok_q, aw_ok_d, ar_ok_q, ar_ok_d;
  logic [31:0] wdata_q, wdata_d;
  logic [WORD_BYTES-1:0] wstrb_q, wstrb_d;

  logic aw_hs, w_hs, ar_hs, wr_commit, wr_ok, ram_re;
  logic [ADDR_BITS-1:0] wr_idx;
  logic [31:0] wr_data, ram_rdata;
  logic [WORD_BYTES-1:0] wr_strb;
  logic unused_bits;

  assign aw_hs = bus.AWvalid && awready_q;
  assign w_hs  = bus.Wvalid && wready_q;
  assign ar_hs = bus.ARvalid && arready_q;

  // State register: FSM states plus every registered output and latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      bus_err_q <= 1'b0;
      aw_idx_q  <= '0;
      ar_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      ar_ok_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      bus_err_q <= bus_err_d;
      aw_idx_q  <= aw_idx_d;
      ar_idx_q  <= ar_idx_d;
      aw_ok_q   <= aw_ok_d;
      ar_ok_q   <= ar_ok_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_d = W_RESP;
        else if (aw_hs)    w_state_d = W_HAVE_A;
        else if (w_hs)     w_state_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)  w_state_d = W_RESP;
      W_HAVE_D: if (aw_hs) w_state_d = W_RESP;
      W_RESP:   if (bvalid_q && bus.Bready) w_state_d = W_IDLE;
      default:  w_state_d = W_IDLE;
    endcase

    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_READ;
      R_READ:  r_state_d = R_DATA;
      R_DATA:  if (rvalid_q && bus.RReady) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they track it cycle-exact.
  always_comb begin
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
    bvalid_d  = (w_state_d == W_RESP);
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);

    aw_idx_d = aw_hs ? bus.AWdata[TAG_LSB-1:LSB] : aw_idx_q;
    aw_ok_d  = aw_hs ? in_win(bus.AWdata)        : aw_ok_q;
    wdata_d  = w_hs  ? bus.Wdata                 : wdata_q;
    wstrb_d  = w_hs  ? bus.Wstrb                 : wstrb_q;
    ar_idx_d = ar_hs ? bus.ARdata[TAG_LSB-1:LSB] : ar_idx_q;
    ar_ok_d  = ar_hs ? in_win(bus.ARdata)        : ar_ok_q;

    // The half that arrives last is taken straight off the bus.
    wr_commit = (w_state_q != W_RESP) && (w_state_d == W_RESP);
    wr_idx    = (w_state_q == W_HAVE_A) ? aw_idx_q : bus.AWdata[TAG_LSB-1:LSB];
    wr_ok     = (w_state_q == W_HAVE_A) ? aw_ok_q  : in_win(bus.AWdata);
    wr_data   = (w_state_q == W_HAVE_D) ? wdata_q  : bus.Wdata;
    wr_strb   = (w_state_q == W_HAVE_D) ? wstrb_q  : bus.Wstrb;
    ram_re    = (r_state_q == R_READ);

    bus_err_d = (wr_commit && !wr_ok) || (ram_re && !ar_ok_q);
  end

  axi4lite_mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .we    (wr_commit && wr_ok),
    .be    (wr_strb),
    .waddr (wr_idx),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (ar_idx_q),
    .rdata (ram_rdata)
  );

  assign bus.AWready = awready_q;
  assign bus.Wready  = wready_q;
  assign bus.Bvalid  = bvalid_q;
  assign bus.ARready = arready_q;
  assign bus.Rvalid  = rvalid_q;
  assign bus.Rdata   = (rvalid_q && ar_ok_q) ? ram_rdata : ERR_RDATA;
  assign bus_err     = bus_err_q;
  assign w_state_dbg = w_state_q;
  assign r_state_dbg = r_state_q;

  assign unused_bits = ^{bus.AWprot, bus.ARprot, bus.AWdata[LSB-1:0], bus.ARdata[LSB-1:0]};

endmodule
